mac_accumulate_stage: RTL and testbench

Sequential accumulator stage that sits directly downstream of the 2-bit multiplier array in the reconfigurable MAC datapath. It consumes one beat of LANES 4-bit unsigned partial products per accepted handshake and accumulates them into per-lane registers (independent mode) or one fused dot-product register (fused mode). On the frame's last beat it presents the result to the next stage under a valid/ready handshake.

---
 rtl/mac_accumulate_stage.sv | 92 +++++++++
 tb/tb_mac_accumulate_stage.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/mac_accumulate_stage.sv
// mac_accumulate_stage: per-lane or fused accumulator for the multiplier array, result handed off by valid/ready.
// Define MAC_ACC_SAT_EN for saturating adds with a sticky ovf; otherwise adds wrap and ovf is 0.
module mac_accumulate_stage #(
  parameter int LANES = 4,
  parameter int ACC_W = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mode,
  input  logic [4*LANES-1:0]     prod,
  input  logic                   in_valid,
  input  logic                   in_last,
  output logic                   in_ready,
  output logic [ACC_W*LANES-1:0] acc_out,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [7:0]             beat_cnt,
  output logic                   ovf
);
`ifdef MAC_ACC_SAT_EN
  localparam int SW = ACC_W + 1;
`else
  localparam int SW = ACC_W;
`endif
  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
  state_t state, state_n;
  logic mode_q, eff_mode, accept, handoff;
  logic [ACC_W-1:0] acc [LANES];
  logic [ACC_W-1:0] nxt [LANES];
  logic [SW-1:0] add [LANES];
  logic [SW-1:0] fsum;
`ifdef MAC_ACC_SAT_EN
  logic [LANES-1:0] lane_ovf;
`endif
  assign accept   = in_valid && in_ready;
  assign handoff  = out_valid && out_ready;
  // mode is only honoured on a frame's first beat; later beats use the latched copy
  assign eff_mode = (state == IDLE) ? mode : mode_q;
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end
  always_comb begin
    state_n = state;
    if (state == DONE) state_n = handoff ? IDLE : DONE;
    else if (accept)   state_n = in_last ? DONE : ACC;
  end
  always_comb begin
    in_ready  = state != DONE;
    out_valid = state == DONE;
  end
  always_comb begin
    fsum = '0;
    for (int i = 0; i < LANES; i++) fsum = fsum + SW'(prod[4*i +: 4]);
    for (int i = 0; i < LANES; i++) begin
      add[i] = SW'(acc[i]) + (eff_mode ? ((i == 0) ? fsum : '0) : SW'(prod[4*i +: 4]));
`ifdef MAC_ACC_SAT_EN
      lane_ovf[i] = add[i][ACC_W];
      nxt[i]      = lane_ovf[i] ? '1 : add[i][ACC_W-1:0];
`else
      nxt[i]      = add[i];
`endif
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q   <= 1'b0;
      beat_cnt <= '0;
      for (int i = 0; i < LANES; i++) acc[i] <= '0;
    end else begin
      if (state == IDLE && accept) mode_q <= mode;
      if (accept) begin
        beat_cnt <= (beat_cnt == 8'hff) ? beat_cnt : beat_cnt + 8'd1;
        for (int i = 0; i < LANES; i++) acc[i] <= nxt[i];
      end else if (handoff) begin
        beat_cnt <= '0;
        for (int i = 0; i < LANES; i++) acc[i] <= '0;
      end
    end
  end
`ifdef MAC_ACC_SAT_EN
  always_ff @(posedge clk) begin
    if (rst || handoff)          ovf <= 1'b0;
    else if (accept && |lane_ovf) ovf <= 1'b1;
  end
`else
  assign ovf = 1'b0;
`endif
  for (genvar g = 0; g < LANES; g++) begin : g_out
    assign acc_out[ACC_W*g +: ACC_W] = acc[g];
  end
endmodule

// File: tb/tb_mac_accumulate_stage.sv
// tb_mac_accumulate_stage: directed scoreboard bench for mac_accumulate_stage (12-bit and 6-bit instances).
module tb_mac_accumulate_stage;
  logic clk = 1'b0, rst = 1'b1, mode = 1'b0, in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [15:0] prod = '0;
  logic in_ready, out_valid, ovf;
  logic [47:0] acc_out;
  logic [7:0] beat_cnt;
  logic s_mode = 1'b0, s_valid = 1'b0, s_last = 1'b0, s_out_ready = 1'b0;
  logic [15:0] s_prod = '0;
  logic s_in_ready, s_out_valid, s_ovf;
  logic [23:0] s_acc;
  logic [7:0] s_beat;
  int tests = 0, fails = 0;
  typedef struct packed {logic [47:0] acc; logic [7:0] cnt; logic ovf;} exp_t;
  exp_t exp_q[$], s_exp_q[$];
  exp_t e, se;

  always #5 clk = ~clk;

  mac_accumulate_stage #(.LANES(4), .ACC_W(12)) dut (
    .clk(clk), .rst(rst), .mode(mode), .prod(prod), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .acc_out(acc_out), .out_valid(out_valid), .out_ready(out_ready),
    .beat_cnt(beat_cnt), .ovf(ovf));

  mac_accumulate_stage #(.LANES(4), .ACC_W(6)) sdut (
    .clk(clk), .rst(rst), .mode(s_mode), .prod(s_prod), .in_valid(s_valid), .in_last(s_last),
    .in_ready(s_in_ready), .acc_out(s_acc), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .beat_cnt(s_beat), .ovf(s_ovf));

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic beat(input logic [15:0] p, input logic m, input logic l);
    prod = p; mode = m; in_last = l; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic do_handoff();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  // monitors: compare every presented result against the scoreboard
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_result: got acc %0h with empty scoreboard", acc_out);
      end else begin
        e = exp_q.pop_front();
        chk("res_acc", acc_out, e.acc);
        chk("res_cnt", beat_cnt, e.cnt);
        chk("res_ovf", ovf, e.ovf);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && s_out_valid && s_out_ready) begin
      if (s_exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL s_unexpected_result: got acc %0h with empty scoreboard", s_acc);
      end else begin
        se = s_exp_q.pop_front();
        chk("s_res_acc", s_acc, se.acc);
        chk("s_res_cnt", s_beat, se.cnt);
        chk("s_res_ovf", s_ovf, se.ovf);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_acc", acc_out, 0);
    chk("rst_cnt", beat_cnt, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_s_in_ready", s_in_ready, 1);
    rst = 1'b0;
    // stray in_last without in_valid
    in_last = 1'b1;
    @(posedge clk); #1;
    in_last = 1'b0;
    chk("stray_last_ov", out_valid, 0);
    chk("stray_last_cnt", beat_cnt, 0);
    // independent mode, three beats of {1,2,3,4}
    exp_q.push_back('{acc: {12'd0, 12'd0, 12'd0, 12'd0} | {12'd12, 12'd9, 12'd6, 12'd3}, cnt: 8'd3, ovf: 1'b0});
    beat(16'h4321, 1'b0, 1'b0);
    chk("ind_b1_acc", acc_out, {12'd4, 12'd3, 12'd2, 12'd1});
    beat(16'h4321, 1'b0, 1'b0);
    beat(16'h4321, 1'b0, 1'b1);
    chk("ind_ov", out_valid, 1);
    chk("ind_rdy", in_ready, 0);
    chk("ind_cnt", beat_cnt, 3);
    do_handoff();
    chk("clr_acc", acc_out, 0);
    chk("clr_ov", out_valid, 0);
    chk("clr_rdy", in_ready, 1);
    chk("clr_cnt", beat_cnt, 0);
    // fused mode, mode dropped on second beat
    exp_q.push_back('{acc: 48'd72, cnt: 8'd2, ovf: 1'b0});
    beat(16'h9999, 1'b1, 1'b0);
    chk("fused_mid", acc_out, 48'd36);
    beat(16'h9999, 1'b0, 1'b1);
    // backpressure in DONE with upstream pushing
    prod = 16'h1111; in_valid = 1'b1; in_last = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      chk("bp_rdy", in_ready, 0);
      chk("bp_acc", acc_out, 48'd72);
      chk("bp_cnt", beat_cnt, 2);
    end
    in_valid = 1'b0; in_last = 1'b0;
    do_handoff();
    chk("bp_rdy_after", in_ready, 1);
    chk("bp_clr", acc_out, 0);
    // overflow on the 6-bit instance
`ifdef MAC_ACC_SAT_EN
    s_exp_q.push_back('{acc: 48'd63, cnt: 8'd2, ovf: 1'b1});
`else
    s_exp_q.push_back('{acc: 48'd8, cnt: 8'd2, ovf: 1'b0});
`endif
    s_mode = 1'b1; s_prod = 16'h9999; s_valid = 1'b1;
    @(posedge clk); #1;
    chk("s_b1_acc", s_acc, 24'd36);
    chk("s_b1_ovf", s_ovf, 0);
    s_mode = 1'b0; s_last = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
    chk("s_ov", s_out_valid, 1);
    s_out_ready = 1'b1;
    @(posedge clk); #1;
    s_out_ready = 1'b0;
    chk("s_clr_acc", s_acc, 0);
    chk("s_clr_ovf", s_ovf, 0);
    // reset mid-frame discards the partial frame
    beat(16'h4321, 1'b0, 1'b0);
    beat(16'h4321, 1'b0, 1'b0);
    chk("mid_cnt", beat_cnt, 2);
    chk("mid_acc", acc_out, {12'd8, 12'd6, 12'd4, 12'd2});
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_acc", acc_out, 0);
    chk("mid_rst_cnt", beat_cnt, 0);
    chk("mid_rst_rdy", in_ready, 1);
    exp_q.push_back('{acc: {12'd1, 12'd1, 12'd1, 12'd1}, cnt: 8'd1, ovf: 1'b0});
    beat(16'h1111, 1'b0, 1'b1);
    chk("single_ov", out_valid, 1);
    do_handoff();
    // back-to-back 260-beat frame saturates beat_cnt
    exp_q.push_back('{acc: 48'd260, cnt: 8'd255, ovf: 1'b0});
    prod = 16'h0001; mode = 1'b0; in_valid = 1'b1;
    repeat (259) @(posedge clk);
    #1;
    in_last = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    chk("long_cnt", beat_cnt, 255);
    chk("long_acc", acc_out, 48'd260);
    do_handoff();
    repeat (3) @(posedge clk);
    #1;
    chk("q_empty", exp_q.size(), 0);
    chk("s_q_empty", s_exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
